conv1_kload_ctrl: RTL and testbench

Sequencer for the conv1 kernel-weight ROM, a dual-port 64×16 ROM with one-cycle registered reads. On a start request it walks one kernel's 25 weights, two per cycle through ports A/B, and streams them as weight pairs to the conv1 MAC array over a valid/ready handshake. A 2-entry skid buffer absorbs ROM read latency under backpressure. It sits between the top-level layer FSM, which issues start and kernel_sel, and the kernel ROM plus MAC array.

---
 rtl/conv1_kload_ctrl.sv | 148 ++++++++++++++
 tb/tb_conv1_kload_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv1_kload_ctrl.sv
// rtl/conv1_kload_ctrl.sv - conv1 kernel ROM sequencer streaming weight pairs; CONV1_KLOAD_SUM_EN adds kernel_sum
module conv1_kload_ctrl #(
   parameter int DATA_W     = 16,
   parameter int ADDR_W     = 6,
   parameter int KERNEL_LEN = 25,
   parameter int SLOT_SHIFT = 5,
   parameter int SEL_W      = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic [SEL_W-1:0]  kernel_sel,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] address_a,
   output logic [ADDR_W-1:0] address_b,
   input  logic [DATA_W-1:0] q_a,
   input  logic [DATA_W-1:0] q_b,
   output logic [DATA_W-1:0] w_a,
   output logic [DATA_W-1:0] w_b,
   output logic              w_b_en,
   output logic [3:0]        w_idx,
   output logic              w_valid,
   input  logic              w_ready
`ifdef CONV1_KLOAD_SUM_EN
   ,
   output logic signed [DATA_W+4:0] kernel_sum
`endif
);

   localparam int NPAIRS = (KERNEL_LEN + 1) / 2;
   localparam logic [3:0] LAST_IDX = 4'(NPAIRS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] base, hold_a, hold_b, issue_a, issue_b;
   logic [3:0]        n;
   logic [1:0]        c;
   logic              infl_v, infl_b_en;
   logic [3:0]        infl_idx;
   logic [DATA_W-1:0] fa [2];
   logic [DATA_W-1:0] fb [2];
   logic              fb_en [2];
   logic [3:0]        fidx [2];
   logic              wp, rp;
   logic [1:0]        cnt;
   logic              pop, issue, b_en_now;
   logic [4:0]        two_n;

   assign pop      = (cnt != 2'd0) && w_ready;
   // c counts in-flight plus buffered pairs; a pop this cycle frees a slot immediately
   assign issue    = (state == FETCH) && (({1'b0, c} - {2'b00, pop}) < 3'd2);
   assign two_n    = {n, 1'b0};
   assign b_en_now = (int'(two_n) + 1) < KERNEL_LEN;
   assign issue_a  = base + ADDR_W'(two_n);
   assign issue_b  = b_en_now ? base + ADDR_W'(two_n) + ADDR_W'(1)
                              : base + ADDR_W'(KERNEL_LEN - 1);

   assign address_a = issue ? issue_a : hold_a;
   assign address_b = issue ? issue_b : hold_b;

   assign w_valid = (cnt != 2'd0);
   assign w_a     = fa[rp];
   assign w_b     = fb[rp];
   assign w_b_en  = fb_en[rp];
   assign w_idx   = fidx[rp];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         base      <= '0;
         hold_a    <= '0;
         hold_b    <= '0;
         n         <= '0;
         c         <= '0;
         infl_v    <= 1'b0;
         infl_b_en <= 1'b0;
         infl_idx  <= '0;
         wp        <= 1'b0;
         rp        <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fa[i]    <= '0;
            fb[i]    <= '0;
            fb_en[i] <= 1'b0;
            fidx[i]  <= '0;
         end
`ifdef CONV1_KLOAD_SUM_EN
         kernel_sum <= '0;
`endif
      end else begin
         done   <= 1'b0;
         infl_v <= issue;
         if (issue) begin
            infl_b_en <= b_en_now;
            infl_idx  <= n;
            hold_a    <= issue_a;
            hold_b    <= issue_b;
            n         <= n + 4'd1;
         end
         c <= c + {1'b0, issue} - {1'b0, pop};

         if (infl_v) begin
            fa[wp]    <= q_a;
            fb[wp]    <= q_b;
            fb_en[wp] <= infl_b_en;
            fidx[wp]  <= infl_idx;
            wp        <= ~wp;
         end
         if (pop)
            rp <= ~rp;
         cnt <= cnt + {1'b0, infl_v} - {1'b0, pop};

`ifdef CONV1_KLOAD_SUM_EN
         if (pop)
            kernel_sum <= kernel_sum + {{5{w_a[DATA_W-1]}}, w_a}
                        + (w_b_en ? {{5{w_b[DATA_W-1]}}, w_b} : '0);
`endif

         case (state)
            IDLE: if (start) begin
               base  <= ADDR_W'(kernel_sel) << SLOT_SHIFT;
               n     <= '0;
               c     <= '0;
               busy  <= 1'b1;
               state <= FETCH;
`ifdef CONV1_KLOAD_SUM_EN
               kernel_sum <= '0;
`endif
            end
            FETCH: if (issue && n == LAST_IDX)
               state <= DRAIN;
            DRAIN: if (c == 2'd1 && pop) begin
               state  <= IDLE;
               busy   <= 1'b0;
               done   <= 1'b1;
               hold_a <= base;
               hold_b <= base;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv1_kload_ctrl.sv
// tb/tb_conv1_kload_ctrl.sv - scoreboard bench for conv1_kload_ctrl with registered dual-port ROM model
module tb_conv1_kload_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [0:0]  kernel_sel = 1'b0;
   logic        busy, done;
   logic [5:0]  address_a, address_b;
   logic [15:0] q_a, q_b;
   logic [15:0] w_a, w_b;
   logic        w_b_en;
   logic [3:0]  w_idx;
   logic        w_valid;
   logic        w_ready = 1'b0;
`ifdef CONV1_KLOAD_SUM_EN
   logic signed [20:0] kernel_sum;
`endif

   conv1_kload_ctrl dut (
      .clock(clock), .reset_n(reset_n), .start(start), .kernel_sel(kernel_sel),
      .busy(busy), .done(done), .address_a(address_a), .address_b(address_b),
      .q_a(q_a), .q_b(q_b), .w_a(w_a), .w_b(w_b), .w_b_en(w_b_en),
      .w_idx(w_idx), .w_valid(w_valid), .w_ready(w_ready)
`ifdef CONV1_KLOAD_SUM_EN
      , .kernel_sum(kernel_sum)
`endif
   );

   always #5 clock = ~clock;

   logic [15:0] rom [64];
   always @(posedge clock) begin
      q_a <= rom[address_a];
      q_b <= rom[address_b];
   end

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        b_en;
      logic [3:0]  idx;
   } pair_t;

   pair_t exp_q [$];
   pair_t e_m;
   int compared = 0;
   int mismatched = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [0:0] sel);
      pair_t p;
      int base;
      base = int'(sel) * 32;
      for (int n = 0; n < 13; n++) begin
         p.a    = rom[base + 2*n];
         p.b_en = (2*n + 1) < 25;
         p.b    = p.b_en ? rom[base + 2*n + 1] : rom[base + 24];
         p.idx  = 4'(n);
         exp_q.push_back(p);
      end
   endtask

   logic        stalled = 1'b0;
   logic [36:0] held;
   always @(negedge clock) begin
      if (reset_n && w_valid) begin
         if (stalled)
            chk("stall_hold", {27'd0, w_a, w_b, w_b_en, w_idx}, {27'd0, held});
         if (w_ready) begin
            if (exp_q.size() == 0)
               chk("pop_unexpected", 64'd1, 64'd0);
            else begin
               e_m = exp_q.pop_front();
               chk("pair", {27'd0, w_a, w_b, w_b_en, w_idx},
                   {27'd0, e_m.a, e_m.b, e_m.b_en, e_m.idx});
            end
            stalled = 1'b0;
         end else begin
            stalled = 1'b1;
            held = {w_a, w_b, w_b_en, w_idx};
         end
      end else
         stalled = 1'b0;
   end

   function automatic logic rdy(input int mode, input int k);
      case (mode)
         1:       return ((k - 1) % 4 == 0) || ((k - 1) % 4 == 3);
         2:       return k > 20;
         default: return 1'b1;
      endcase
   endfunction

   // mode 0: ready high, 1: ready 1,0,0,1 pattern, 2: ready low for 20 cycles
   task automatic run_kernel(input logic [0:0] sel, input int mode, input int again_cyc,
                             input int exp_done);
      int k;
      int done_cyc;
      push_exp(sel);
      done_cyc = -1;
      @(posedge clock); #1;
      start = 1'b1; kernel_sel = sel; w_ready = rdy(mode, 0);
      @(posedge clock); #1;
      start = 1'b0; kernel_sel = ~sel; k = 1; w_ready = rdy(mode, 1);
      while (k <= 300) begin
         @(negedge clock);
         if (mode == 0) begin
            chk("w_valid_timing", {63'd0, w_valid}, {63'd0, (k >= 3 && k <= 15)});
            chk("done_timing", {63'd0, done}, {63'd0, (k == 16)});
            chk("busy_timing", {63'd0, busy}, {63'd0, (k <= 15)});
         end
         if (mode == 2 && k == 20) begin
            chk("stall_addr_a", {58'd0, address_a}, 64'(int'(sel) * 32 + 2));
            chk("stall_addr_b", {58'd0, address_b}, 64'(int'(sel) * 32 + 3));
            chk("stall_valid", {63'd0, w_valid}, 64'd1);
            chk("stall_idx", {60'd0, w_idx}, 64'd0);
         end
         if (done) begin
            done_cyc = k;
            break;
         end
         @(posedge clock); #1;
         k++;
         w_ready = rdy(mode, k);
         if (k == again_cyc) begin
            start = 1'b1; kernel_sel = 1'b1;
         end else
            start = 1'b0;
      end
      start = 1'b0;
      chk("done_cycle", 64'(done_cyc), 64'(exp_done));
      chk("queue_drained", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) rom[i] = 16'(i);
      reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("reset_ctl", {60'd0, busy, done, w_valid, w_b_en}, 64'd0);
      chk("reset_data", {28'd0, w_a, w_b, w_idx}, 64'd0);
      chk("reset_addr", {52'd0, address_a, address_b}, 64'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;

      run_kernel(1'b1, 0, -1, 16);
      run_kernel(1'b0, 1, -1, 29);
      run_kernel(1'b0, 0, 5, 16);

      push_exp(1'b1);
      @(posedge clock); #1;
      start = 1'b1; kernel_sel = 1'b1; w_ready = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int k = 2; k <= 8; k++) begin
         @(posedge clock); #1;
      end
      reset_n = 1'b0;
      exp_q.delete();
      @(negedge clock);
      chk("midrst_busy_valid", {62'd0, busy, w_valid}, 64'd0);
      chk("midrst_addr", {52'd0, address_a, address_b}, 64'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      run_kernel(1'b0, 0, -1, 16);

      run_kernel(1'b0, 2, -1, 34);
`ifdef CONV1_KLOAD_SUM_EN
      chk("kernel_sum_ramp", 64'(int'(kernel_sum)), 64'(300));
      for (int i = 0; i < 64; i++) rom[i] = 16'hFFFF;
      run_kernel(1'b1, 0, -1, 16);
      chk("kernel_sum_neg", 64'(int'(kernel_sum)), 64'(-25));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
